// File: rtl/miso_fifo_sched.sv
// miso_fifo_sched: round-robin arbiter for the MISO FIFO write port, and a
// sequencer that pulls each 43-bit word back out as three 16-bit segments
// and hands them to the SPI shifter over a valid/ready handshake.
module miso_fifo_sched #(
   parameter int NUM_REQ = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NUM_REQ-1:0]     req_valid,
   input  logic [NUM_REQ*43-1:0]  req_data,
   output logic [NUM_REQ-1:0]     req_ready,
   output logic                   fifo_write_enable,
   output logic [42:0]            fifo_data_in,
   input  logic                   fifo_full,
   input  logic                   fifo_empty,
   output logic                   fifo_read_enable,
   input  logic [15:0]            fifo_data_out,
   input  logic                   fifo_segment_valid,
   output logic                   tx_valid,
   output logic [15:0]            tx_data,
   output logic                   tx_last,
   input  logic                   tx_ready,
   output logic                   seq_err
);
   localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
   localparam logic [PTR_W-1:0] LAST_IDX = PTR_W'(NUM_REQ - 1);

   typedef enum logic [1:0] {S_IDLE, S_READ, S_WAIT, S_HOLD} state_t;

   logic [42:0]      req_word [NUM_REQ];
   logic [PTR_W-1:0] rr_ptr_q, rr_ptr_d;
   logic [PTR_W-1:0] grant_idx;
   logic [PTR_W-1:0] cand_idx;
   logic             grant_found;

   state_t           state_q, state_d;
   logic [1:0]       seg_cnt_q, seg_cnt_d;
   logic             rd_en_q, rd_en_d;
   logic             tx_valid_q, tx_valid_d;
   logic [15:0]      tx_data_q, tx_data_d;
   logic             tx_last_q, tx_last_d;
   logic             seq_err_q, seq_err_d;

   for (genvar gi = 0; gi < NUM_REQ; gi++) begin : g_slice
      assign req_word[gi] = req_data[43*gi +: 43];
   end

   // Find the first valid requester at or after rr_ptr, wrapping modulo NUM_REQ
   always_comb begin
      grant_found = 1'b0;
      grant_idx   = '0;
      cand_idx    = '0;
      for (int k = 0; k < NUM_REQ; k++) begin
         cand_idx = PTR_W'((int'(rr_ptr_q) + k) % NUM_REQ);
         if (!grant_found && req_valid[cand_idx]) begin
            grant_found = 1'b1;
            grant_idx   = cand_idx;
         end
      end
   end

   // Issue the one-hot grant and present its word; nothing is granted while full or in reset
   always_comb begin
      req_ready    = '0;
      fifo_data_in = '0;
      if (grant_found && !fifo_full && !rst) begin
         req_ready[grant_idx] = 1'b1;
         fifo_data_in         = req_word[grant_idx];
      end
   end

   assign fifo_write_enable = |req_ready;
   assign rr_ptr_d = !fifo_write_enable     ? rr_ptr_q :
                     (grant_idx == LAST_IDX) ? '0       : grant_idx + 1'b1;

   // Segment read sequencer: READ strobes the FIFO, WAIT captures, HOLD offers to the shifter
   always_comb begin
      state_d    = state_q;
      seg_cnt_d  = seg_cnt_q;
      rd_en_d    = 1'b0;
      tx_valid_d = tx_valid_q;
      tx_data_d  = tx_data_q;
      tx_last_d  = tx_last_q;
      seq_err_d  = seq_err_q;
      case (state_q)
         S_IDLE: begin
            if (!fifo_empty) begin
               state_d = S_READ;
               rd_en_d = 1'b1;
            end
         end
         S_READ: begin
            state_d = S_WAIT;
         end
         S_WAIT: begin
            if (fifo_segment_valid) begin
               tx_data_d  = fifo_data_out;
               tx_last_d  = (seg_cnt_q == 2'd2);
               tx_valid_d = 1'b1;
               state_d    = S_HOLD;
            end else begin
               seq_err_d = 1'b1;
               seg_cnt_d = 2'd0;
               state_d   = S_IDLE;
            end
         end
         S_HOLD: begin
            if (tx_ready) begin
               tx_valid_d = 1'b0;
               tx_last_d  = 1'b0;
               if (seg_cnt_q != 2'd2) begin
                  seg_cnt_d = seg_cnt_q + 2'd1;
                  state_d   = S_READ;
                  rd_en_d   = 1'b1;
               end else begin
                  seg_cnt_d = 2'd0;
                  if (!fifo_empty) begin
                     state_d = S_READ;
                     rd_en_d = 1'b1;
                  end else begin
                     state_d = S_IDLE;
                  end
               end
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // All state, including the round-robin pointer, clears on reset
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rr_ptr_q   <= '0;
         state_q    <= S_IDLE;
         seg_cnt_q  <= 2'd0;
         rd_en_q    <= 1'b0;
         tx_valid_q <= 1'b0;
         tx_data_q  <= 16'd0;
         tx_last_q  <= 1'b0;
         seq_err_q  <= 1'b0;
      end else begin
         rr_ptr_q   <= rr_ptr_d;
         state_q    <= state_d;
         seg_cnt_q  <= seg_cnt_d;
         rd_en_q    <= rd_en_d;
         tx_valid_q <= tx_valid_d;
         tx_data_q  <= tx_data_d;
         tx_last_q  <= tx_last_d;
         seq_err_q  <= seq_err_d;
      end
   end

   assign fifo_read_enable = rd_en_q;
   assign tx_valid         = tx_valid_q;
   assign tx_data          = tx_data_q;
   assign tx_last          = tx_last_q;
   assign seq_err          = seq_err_q;

endmodule

// File: tb/tb_miso_fifo_sched.sv
// tb_miso_fifo_sched: directed bench with a behavioural 8-word segmented FIFO.
module tb_miso_fifo_sched;
   localparam int N = 4;

   logic           clk = 1'b0;
   logic           rst;
   logic [N-1:0]   req_valid;
   logic [N*43-1:0] req_data;
   logic [N-1:0]   req_ready;
   logic           fifo_write_enable;
   logic [42:0]    fifo_data_in;
   logic           fifo_full, fifo_empty;
   logic           fifo_read_enable;
   logic [15:0]    fifo_data_out;
   logic           fifo_segment_valid;
   logic           tx_valid;
   logic [15:0]    tx_data;
   logic           tx_last;
   logic           tx_ready;
   logic           seq_err;

   miso_fifo_sched #(.NUM_REQ(N)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_data(req_data), .req_ready(req_ready),
      .fifo_write_enable(fifo_write_enable), .fifo_data_in(fifo_data_in),
      .fifo_full(fifo_full), .fifo_empty(fifo_empty),
      .fifo_read_enable(fifo_read_enable), .fifo_data_out(fifo_data_out),
      .fifo_segment_valid(fifo_segment_valid),
      .tx_valid(tx_valid), .tx_data(tx_data), .tx_last(tx_last),
      .tx_ready(tx_ready), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- behavioural FIFO: 8 words, three segment reads per word
   logic [42:0] mem [8];
   logic [2:0]  wp, rp;
   int          cnt;
   logic [1:0]  seg;
   logic [15:0] seg_q;
   logic        segv_q;
   logic        full_ovr, kill_valid;
   logic        push, pop;
   logic [42:0] cur_word;
   logic [15:0] seg_val;

   assign fifo_empty         = (cnt == 0);
   assign fifo_full          = (cnt == 8) || full_ovr;
   assign fifo_data_out      = seg_q;
   assign fifo_segment_valid = segv_q;
   assign push     = fifo_write_enable && (cnt < 8);
   assign pop      = fifo_read_enable && (cnt > 0) && (seg == 2'd2);
   assign cur_word = mem[rp];

   always_comb begin
      seg_val = 16'd0;
      case (seg)
         2'd0:    seg_val = cur_word[15:0];
         2'd1:    seg_val = cur_word[31:16];
         default: seg_val = {5'd0, cur_word[42:32]};
      endcase
   end

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         wp <= '0; rp <= '0; cnt <= 0; seg <= '0; seg_q <= '0; segv_q <= 1'b0;
      end else begin
         if (push) begin
            mem[wp] <= fifo_data_in;
            wp      <= wp + 3'd1;
         end
         segv_q <= fifo_read_enable && (cnt > 0) && !kill_valid;
         if (fifo_read_enable) begin
            seg_q <= seg_val;
            if (cnt > 0) seg <= (seg == 2'd2) ? 2'd0 : seg + 2'd1;
         end
         if (pop) rp <= rp + 3'd1;
         cnt <= cnt + int'(push) - int'(pop);
      end
   end

   // One line per transaction on either side
   always @(negedge clk) begin
      if (!rst && fifo_write_enable)
         $display("[%0d] wr grant=%b data=%h", cyc, req_ready, fifo_data_in);
      if (!rst && tx_valid && tx_ready)
         $display("[%0d] tx data=%h last=%b", cyc, tx_data, tx_last);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   logic [42:0] word_c [N];

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Drive one word from requester idx; returns at the negedge after the write edge
   task automatic write_word(input int idx, input logic [42:0] w);
      logic [N-1:0] m;
      @(negedge clk);
      req_data[43*idx +: 43] = w;
      m = '0;
      m[idx] = 1'b1;
      req_valid = m;
      #1;
      check("wr_grant", 64'(req_ready), 64'(m));
      check("wr_data", 64'(fifo_data_in), 64'(w));
      @(negedge clk);
      req_valid = '0;
   endtask

   int hs_cyc [3];
   int first_empty, first_rd, first_tx;

   // Collect three handshakes and compare segment data and tx_last
   task automatic collect3(input logic [42:0] w, input string tag);
      int n;
      logic [15:0] exp_seg [3];
      exp_seg[0] = w[15:0];
      exp_seg[1] = w[31:16];
      exp_seg[2] = {5'd0, w[42:32]};
      n = 0;
      first_empty = -1; first_rd = -1; first_tx = -1;
      for (int k = 0; k < 60 && n < 3; k++) begin
         if (k > 0) @(negedge clk);
         if (!fifo_empty && first_empty < 0) first_empty = cyc;
         if (fifo_read_enable && first_rd < 0) first_rd = cyc;
         if (tx_valid && first_tx < 0) first_tx = cyc;
         if (tx_valid && tx_ready) begin
            hs_cyc[n] = cyc;
            check({tag, "_seg_data"}, 64'(tx_data), 64'(exp_seg[n]));
            check({tag, "_seg_last"}, 64'(tx_last), (n == 2) ? 64'd1 : 64'd0);
            n++;
         end
      end
      check({tag, "_handshakes"}, 64'(n), 64'd3);
   endtask

   typedef struct {
      logic [N-1:0] valid;
      logic         full;
      logic [N-1:0] exp_ready;
   } vec_t;
   vec_t vecs [10];

   initial begin
      logic [42:0] exp_data;
      logic [15:0] held;
      int          grant_cyc, last_rd;
      logic        seen_full;

      word_c[0] = 43'h0AA_1111_0000;
      word_c[1] = 43'h155_2222_0101;
      word_c[2] = 43'h2AB_3333_0202;
      word_c[3] = 43'h3CD_4444_0303;
      for (int i = 0; i < N; i++) req_data[43*i +: 43] = word_c[i];
      req_valid = '0; tx_ready = 1'b0; full_ovr = 1'b0; kill_valid = 1'b0;
      rst = 1'b1;

      // Reset values, with all requesters asking
      repeat (2) @(negedge clk);
      req_valid = '1;
      #1;
      check("rst_req_ready", 64'(req_ready), 64'd0);
      check("rst_wr_en", 64'(fifo_write_enable), 64'd0);
      check("rst_data_in", 64'(fifo_data_in), 64'd0);
      check("rst_rd_en", 64'(fifo_read_enable), 64'd0);
      check("rst_tx_valid", 64'(tx_valid), 64'd0);
      check("rst_tx_data", 64'(tx_data), 64'd0);
      check("rst_tx_last", 64'(tx_last), 64'd0);
      check("rst_seq_err", 64'(seq_err), 64'd0);
      req_valid = '0;
      rst = 1'b0;

      // Round-robin table: pointer history is implied by the row order
      vecs[0] = '{4'b1111, 1'b0, 4'b0001};
      vecs[1] = '{4'b1111, 1'b0, 4'b0010};
      vecs[2] = '{4'b1111, 1'b0, 4'b0100};
      vecs[3] = '{4'b1111, 1'b0, 4'b1000};
      vecs[4] = '{4'b1111, 1'b0, 4'b0001};
      vecs[5] = '{4'b1111, 1'b1, 4'b0000};
      vecs[6] = '{4'b1101, 1'b0, 4'b0100};
      vecs[7] = '{4'b1101, 1'b0, 4'b1000};
      vecs[8] = '{4'b0000, 1'b0, 4'b0000};
      vecs[9] = '{4'b1010, 1'b0, 4'b0010};
      for (int v = 0; v < 10; v++) begin
         @(negedge clk);
         req_valid = vecs[v].valid;
         full_ovr  = vecs[v].full;
         #1;
         exp_data = '0;
         for (int j = 0; j < N; j++) if (vecs[v].exp_ready[j]) exp_data = word_c[j];
         check($sformatf("rr_ready_%0d", v), 64'(req_ready), 64'(vecs[v].exp_ready));
         check($sformatf("rr_wr_en_%0d", v), 64'(fifo_write_enable), 64'(|vecs[v].exp_ready));
         check($sformatf("rr_data_%0d", v), 64'(fifo_data_in), 64'(exp_data));
      end
      @(negedge clk);
      req_valid = '0; full_ovr = 1'b0;

      // Single all-ones word drains as FFFF, FFFF, 07FF at 3-cycle spacing
      do_reset();
      tx_ready = 1'b1;
      write_word(0, 43'h7FF_FFFF_FFFF);
      collect3(43'h7FF_FFFF_FFFF, "single");
      check("single_gap01", 64'(hs_cyc[1] - hs_cyc[0]), 64'd3);
      check("single_gap12", 64'(hs_cyc[2] - hs_cyc[1]), 64'd3);
      check("single_empty_to_rd", 64'(first_rd - first_empty), 64'd1);
      check("single_rd_to_txv", 64'(first_tx - first_rd), 64'd2);

      // Full boundary: requester 2 keeps asking while the FIFO fills and then drains
      do_reset();
      tx_ready = 1'b0;
      req_data[43*2 +: 43] = word_c[2];
      req_valid = 4'b0100;
      seen_full = 1'b0; grant_cyc = -1; last_rd = -1;
      for (int k = 0; k < 80 && grant_cyc < 0; k++) begin
         @(negedge clk);
         if (k == 15) tx_ready = 1'b1;
         #1;
         if (fifo_read_enable && cnt > 0 && seg == 2'd2) last_rd = cyc;
         if (fifo_full) begin
            seen_full = 1'b1;
            check("full_no_grant", 64'(req_ready), 64'd0);
         end else if (seen_full) begin
            check("full_release_grant", 64'(req_ready), 64'b0100);
            grant_cyc = cyc;
         end
      end
      check("full_seen", 64'(seen_full), 64'd1);
      check("full_grant_after_last_rd", 64'(grant_cyc - last_rd), 64'd1);
      req_valid = '0;

      // Back-pressure in HOLD for 10 cycles
      do_reset();
      tx_ready = 1'b0;
      write_word(1, word_c[1]);
      for (int k = 0; k < 20 && !tx_valid; k++) @(negedge clk);
      check("bp_tx_valid", 64'(tx_valid), 64'd1);
      held = tx_data;
      check("bp_seg0", 64'(held), 64'(word_c[1][15:0]));
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("bp_hold_valid", 64'(tx_valid), 64'd1);
         check("bp_hold_data", 64'(tx_data), 64'(held));
         check("bp_no_read", 64'(fifo_read_enable), 64'd0);
      end
      tx_ready = 1'b1;
      @(negedge clk);
      check("bp_release_rd", 64'(fifo_read_enable), 64'd1);
      check("bp_release_valid", 64'(tx_valid), 64'd0);

      // Reset mid-word, right after segment 1 is accepted
      for (int k = 0; k < 20 && !tx_valid; k++) @(negedge clk);
      check("mid_seg1", 64'(tx_data), 64'(word_c[1][31:16]));
      @(negedge clk);
      rst = 1'b1;
      req_valid = '1;
      #1;
      check("mid_rst_req_ready", 64'(req_ready), 64'd0);
      check("mid_rst_rd_en", 64'(fifo_read_enable), 64'd0);
      check("mid_rst_tx_valid", 64'(tx_valid), 64'd0);
      check("mid_rst_tx_data", 64'(tx_data), 64'd0);
      check("mid_rst_tx_last", 64'(tx_last), 64'd0);
      check("mid_rst_seq_err", 64'(seq_err), 64'd0);
      @(negedge clk);
      req_valid = '0;
      rst = 1'b0;
      write_word(3, word_c[3]);
      collect3(word_c[3], "fresh");

      // Missing segment-valid sets the sticky error and returns to IDLE
      do_reset();
      kill_valid = 1'b1;
      write_word(0, word_c[0]);
      for (int k = 0; k < 20 && !seq_err; k++) @(negedge clk);
      check("err_set", 64'(seq_err), 64'd1);
      check("err_idle_rd", 64'(fifo_read_enable), 64'd0);
      check("err_idle_txv", 64'(tx_valid), 64'd0);
      repeat (5) @(negedge clk);
      kill_valid = 1'b0;
      repeat (10) @(negedge clk);
      check("err_sticky", 64'(seq_err), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("err_cleared", 64'(seq_err), 64'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
